// File: rtl/sweep_ctrl_pkg.sv
// rtl/sweep_ctrl_pkg.sv - shared state encoding and default widths for the sweep controller
//
// Purpose: holds the 3-bit FSM state type and the default parameter values used by
// sweep_ctrl and sweep_timer.
package sweep_ctrl_pkg;

    localparam int CNT_W_DEF       = 20;
    localparam int DWELL_W_DEF     = 24;
    localparam int IDX_W_DEF       = 16;
    localparam int DIV_RST_CYC_DEF = 2;
    localparam int SETTLE_CYC_DEF  = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_HOLD   = 3'd2,
        S_SETTLE = 3'd3,
        S_DWELL  = 3'd4,
        S_STEP   = 3'd5,
        S_DONE   = 3'd6
    } sweep_state_t;

endpackage

// File: rtl/sweep_timer.sv
// rtl/sweep_timer.sv - loadable down-counter with zero flag, shared by HOLD/SETTLE/DWELL
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load count with load_val this cycle (wins over decrement)
//   load_val    value loaded; a state lasting N cycles loads N-1
//   count       current count; stops at zero
//   zero        count == 0, i.e. current cycle is the last of the timed state
module sweep_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sweep_ctrl.sv
// rtl/sweep_ctrl.sv - steps the ADC clock divider counter through a frequency sweep
//
// Optional feature macro: SWEEP_CONT_EN (continuous sweep; when undefined cont is ignored).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, abort      sweep request (IDLE only) / stop request (any non-IDLE state)
//   cfg_start/stop/step/dwell  sweep configuration, latched on an accepted start
//   cont              continuous mode request
//   counter           divide value to the divider (reset 1)
//   div_rst_n         divider reset, active low (reset 1)
//   busy              state != IDLE
//   point_stb         pulse on the last dwell cycle of each point
//   point_idx         0-based index of the current point, saturating
//   done              pulse when the sweep completes normally
//
// All outputs are registered: they are computed from the next state in the
// combinational process and captured on the same edge as the state register.
module sweep_ctrl
    import sweep_ctrl_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DWELL_W     = DWELL_W_DEF,
    parameter int IDX_W       = IDX_W_DEF,
    parameter int DIV_RST_CYC = DIV_RST_CYC_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [CNT_W-1:0]   cfg_start,
    input  logic [CNT_W-1:0]   cfg_stop,
    input  logic [CNT_W-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cont,
    output logic [CNT_W-1:0]   counter,
    output logic               div_rst_n,
    output logic               busy,
    output logic               point_stb,
    output logic [IDX_W-1:0]   point_idx,
    output logic               done
);

    sweep_state_t state, state_n;

    logic [CNT_W-1:0]   cur, cur_n;
    logic [IDX_W-1:0]   idx_n;
    logic [CNT_W-1:0]   stop_sh, step_sh;
    logic [DWELL_W-1:0] dwell_sh;
    logic               single_sh;

    logic [CNT_W-1:0]   start_fix;
    logic [DWELL_W-1:0] dwell_fix;
    logic               single_fix;
    logic [CNT_W:0]     sum;
    logic               at_end;

    logic               tmr_load;
    logic [DWELL_W-1:0] tmr_val;
    logic [DWELL_W-1:0] tmr_cnt;
    logic               tmr_zero;

    logic [CNT_W-1:0]   counter_n;
    logic               stb_n;

`ifdef SWEEP_CONT_EN
    logic [CNT_W-1:0]   start_sh;
`else
    logic               unused_cont;
    assign unused_cont = cont;
`endif

    // Configuration fix-ups applied while latching the shadow registers.
    assign start_fix  = (cfg_start == '0) ? CNT_W'(1) : cfg_start;
    assign dwell_fix  = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
    assign single_fix = (cfg_stop < start_fix) || (cfg_step == '0);

    // One extra bit so a step past the top of the counter range shows up as a
    // carry instead of wrapping to a small value that would look in range.
    assign sum    = {1'b0, cur} + {1'b0, step_sh};
    assign at_end = single_sh || sum[CNT_W] || (sum[CNT_W-1:0] > stop_sh);

    sweep_timer #(.W(DWELL_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_cnt),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_n  = state;
        cur_n    = cur;
        idx_n    = point_idx;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_LOAD;
                    cur_n   = start_fix;
                    idx_n   = '0;
                end
            end
            S_LOAD: begin
                state_n  = S_HOLD;
                tmr_load = 1'b1;
                tmr_val  = DWELL_W'(DIV_RST_CYC - 1);
            end
            S_HOLD: begin
                if (tmr_zero) begin
                    state_n  = S_SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = DWELL_W'(SETTLE_CYC - 1);
                end
            end
            S_SETTLE: begin
                if (tmr_zero) begin
                    state_n  = S_DWELL;
                    tmr_load = 1'b1;
                    tmr_val  = dwell_sh - 1'b1;
                end
            end
            S_DWELL: begin
                if (tmr_zero) begin
                    state_n = S_STEP;
                end
            end
            S_STEP: begin
                if (at_end) begin
`ifdef SWEEP_CONT_EN
                    if (cont) begin
                        state_n = S_LOAD;
                        cur_n   = start_sh;
                        idx_n   = '0;
                    end else begin
                        state_n = S_DONE;
                    end
`else
                    state_n = S_DONE;
`endif
                end else begin
                    state_n = S_LOAD;
                    cur_n   = sum[CNT_W-1:0];
                    idx_n   = (&point_idx) ? point_idx : point_idx + 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Abort overrides every transition and freezes the sweep position.
        if (abort && (state != S_IDLE)) begin
            state_n  = S_IDLE;
            cur_n    = cur;
            idx_n    = point_idx;
            tmr_load = 1'b0;
        end

        counter_n = (state_n == S_LOAD) ? cur_n : counter;
        // Strobe lands on the cycle where DWELL is entered with a single-cycle
        // dwell, or where the running timer is about to reach zero.
        stb_n = (state_n == S_DWELL) &&
                (((state == S_SETTLE) && (dwell_sh == DWELL_W'(1))) ||
                 ((state == S_DWELL) && (tmr_cnt == DWELL_W'(1))));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cur       <= CNT_W'(1);
            counter   <= CNT_W'(1);
            div_rst_n <= 1'b1;
            busy      <= 1'b0;
            point_stb <= 1'b0;
            point_idx <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cur       <= cur_n;
            counter   <= counter_n;
            div_rst_n <= !((state_n == S_LOAD) || (state_n == S_HOLD));
            busy      <= (state_n != S_IDLE);
            point_stb <= stb_n;
            point_idx <= idx_n;
            done      <= (state_n == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_sh   <= '0;
            step_sh   <= '0;
            dwell_sh  <= DWELL_W'(1);
            single_sh <= 1'b1;
`ifdef SWEEP_CONT_EN
            start_sh  <= CNT_W'(1);
`endif
        end else if ((state == S_IDLE) && start) begin
            stop_sh   <= cfg_stop;
            step_sh   <= cfg_step;
            dwell_sh  <= dwell_fix;
            single_sh <= single_fix;
`ifdef SWEEP_CONT_EN
            start_sh  <= start_fix;
`endif
        end
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb/tb_sweep_ctrl.sv - scoreboard bench for sweep_ctrl
module tb_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, cont;
    logic [19:0] cfg_start, cfg_stop, cfg_step;
    logic [23:0] cfg_dwell;
    logic [19:0] counter;
    logic        div_rst_n, busy, point_stb, done;
    logic [15:0] point_idx;

    always #5 clk = ~clk;

    sweep_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cfg_start (cfg_start),
        .cfg_stop  (cfg_stop),
        .cfg_step  (cfg_step),
        .cfg_dwell (cfg_dwell),
        .cont      (cont),
        .counter   (counter),
        .div_rst_n (div_rst_n),
        .busy      (busy),
        .point_stb (point_stb),
        .point_idx (point_idx),
        .done      (done)
    );

    typedef struct {
        logic [31:0] cnt;
        logic [31:0] idx;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output side of the scoreboard: every strobe must match the oldest expected point.
    always @(negedge clk) begin
        if (rst_n && done) done_cnt++;
        if (rst_n && point_stb) begin
            if (sb.size() == 0) begin
                check("stb_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("stb_counter", {12'd0, counter}, mon_e.cnt);
                check("stb_idx", {16'd0, point_idx}, mon_e.idx);
                check("stb_div_rst_n", {31'd0, div_rst_n}, 32'd1);
            end
        end
    end

    task automatic push_point(input logic [31:0] c, input logic [31:0] i);
        exp_t e;
        e.cnt = c;
        e.idx = i;
        sb.push_back(e);
    endtask

    // Reference model of the sweep: pushes every expected point, returns count and last value.
    task automatic model_sweep(input logic [31:0] s, input logic [31:0] stop,
                               input logic [31:0] step, output int n, output logic [31:0] last);
        logic [31:0] c;
        c = (s == 0) ? 32'd1 : s;
        n = 0;
        if (stop < c || step == 0) begin
            push_point(c, 0);
            n = 1;
        end else begin
            forever begin
                push_point(c, n);
                n++;
                if (c + step > stop) break;
                c = c + step;
            end
        end
        last = c;
    endtask

    task automatic set_cfg(input logic [31:0] s, input logic [31:0] stop,
                           input logic [31:0] step, input logic [31:0] dw);
        cfg_start = s[19:0];
        cfg_stop  = stop[19:0];
        cfg_step  = step[19:0];
        cfg_dwell = dw[23:0];
    endtask

    // Leaves the bench at #1 after the edge that sampled start.
    task automatic pulse_start(input logic with_abort);
        @(posedge clk); #1;
        start = 1'b1;
        abort = with_abort;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic run_sweep(input string tag, input logic [31:0] s, input logic [31:0] stop,
                             input logic [31:0] step, input logic [31:0] dw, input logic with_abort);
        int          n, cyc, d, d0;
        logic [31:0] last;
        set_cfg(s, stop, step, dw);
        model_sweep(s, stop, step, n, last);
        d  = (dw == 0) ? 1 : int'(dw);
        d0 = done_cnt;
        pulse_start(with_abort);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(n * (8 + d) + 50, cyc);
        check({tag, "_cycles"}, cyc, n * (8 + d));
        @(posedge clk); #1;
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, "_counter_end"}, {12'd0, counter}, last);
        check({tag, "_left"}, sb.size(), 0);
        check({tag, "_done_cnt"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cont  = 1'b0;
        set_cfg(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_counter", {12'd0, counter}, 32'd1);
        check("rst_div_rst_n", {31'd0, div_rst_n}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_idx", {16'd0, point_idx}, 32'd0);
        check("rst_stb_done", {30'd0, point_stb, done}, 32'd0);
        rst_n = 1'b1;

        // 1: basic three-point sweep, 39 cycles to done
        run_sweep("t1", 10, 30, 10, 5, 1'b0);
        // 2: all-zero config collapses to a single point at 1 with dwell 1
        run_sweep("t2", 0, 0, 0, 0, 1'b0);
        // 3: step past the top of the range must not wrap
        run_sweep("t3", 32'hFFFF0, 32'hFFFFF, 32'h20, 3, 1'b0);
        // stop below start -> single point
        run_sweep("t3b", 50, 40, 5, 2, 1'b0);

        // 4: abort in the second point's dwell
        set_cfg(10, 30, 10, 5);
        push_point(10, 0);
        d0 = done_cnt;
        pulse_start(1'b0);
        repeat (21) @(posedge clk);
        #1;
        check("t4_in_dwell", {31'd0, div_rst_n}, 32'd1);
        check("t4_idx_pre", {16'd0, point_idx}, 32'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_div_rst_n", {31'd0, div_rst_n}, 32'd1);
        check("t4_counter", {12'd0, counter}, 32'd20);
        repeat (10) @(posedge clk);
        #1;
        check("t4_no_done", done_cnt - d0, 0);
        check("t4_left", sb.size(), 0);
        // restart with start and abort together in IDLE: start wins
        run_sweep("t4r", 10, 30, 10, 5, 1'b1);

        // 5: start ignored while busy, then async reset in HOLD
        set_cfg(10, 30, 10, 5);
        push_point(10, 0);
        pulse_start(1'b0);
        repeat (4) @(posedge clk);
        #1;
        set_cfg(100, 300, 100, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t5_still_busy", {31'd0, busy}, 32'd1);
        repeat (9) @(posedge clk);
        #1;
        check("t5_hold_counter", {12'd0, counter}, 32'd20);
        check("t5_hold_div_rst_n", {31'd0, div_rst_n}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_counter", {12'd0, counter}, 32'd1);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_div_rst_n", {31'd0, div_rst_n}, 32'd1);
        check("t5_rst_idx", {16'd0, point_idx}, 32'd0);
        check("t5_left", sb.size(), 0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_sweep("t5r", 7, 9, 1, 1, 1'b0);

`ifdef SWEEP_CONT_EN
        // 6: continuous mode loops until cont drops at an end point
        begin
            int cyc;
            set_cfg(4, 8, 4, 2);
            push_point(4, 0);
            push_point(8, 1);
            push_point(4, 0);
            push_point(8, 1);
            cont = 1'b1;
            d0 = done_cnt;
            pulse_start(1'b0);
            repeat (25) @(posedge clk);
            #1;
            check("t6_no_done_yet", done_cnt - d0, 0);
            check("t6_busy", {31'd0, busy}, 32'd1);
            cont = 1'b0;
            wait_done(200, cyc);
            check("t6_cycles", cyc, 15);
            @(posedge clk); #1;
            check("t6_counter_end", {12'd0, counter}, 32'd8);
            check("t6_left", sb.size(), 0);
            check("t6_done_cnt", done_cnt - d0, 1);
        end
`else
        // cont is ignored without the feature: the sweep still ends in DONE
        cont = 1'b1;
        run_sweep("t6", 4, 8, 4, 2, 1'b0);
        cont = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
